// File: rtl/dst7_16_pkg.sv
// Shared types and row/beat product selection for the 16-point DST-7 column accumulator.
package dst7_16_pkg;

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  localparam int N = 16;

  // Returns {zero, neg, idx}: which SAU product row k uses at beat n, and its sign.
  function automatic logic [5:0] sel_idx(input logic [3:0] k, input logic [3:0] n);
    int p;
    logic zero, neg;
    logic [3:0] idx;
    p    = ((2 * int'(k) + 1) * (int'(n) + 1)) % 66;
    zero = 1'b0;
    neg  = 1'b0;
    idx  = 4'd0;
    if (p == 0 || p == 33) zero = 1'b1;
    else if (p <= 16) idx = 4'(p - 1);
    else if (p <= 32) idx = 4'(32 - p);
    else if (p <= 49) begin neg = 1'b1; idx = 4'(p - 34); end
    else begin neg = 1'b1; idx = 4'(65 - p); end
    return {zero, neg, idx};
  endfunction

endpackage

// File: rtl/dst7_16_mac_lane.sv
// One output row: picks the signed SAU product for this row and beat, accumulates over a frame.
module dst7_16_mac_lane
  import dst7_16_pkg::*;
#(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N-1:0][PROD_W-1:0]     i_prod,
  input  logic [3:0]                   i_k,
  input  logic [3:0]                   i_n,
  input  logic                         i_first,
  input  logic                         i_en,
  output logic [ACC_W-1:0]             o_acc
);

  logic [5:0]        w_sel;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_ext;
  logic [ACC_W-1:0]  w_term;
  logic [ACC_W-1:0]  r_acc;

  assign w_sel  = sel_idx(i_k, i_n);
  assign w_prod = i_prod[w_sel[3:0]];
  // sign-extend (or truncate) the product into the accumulator width
  assign w_ext  = ACC_W'($signed(w_prod));

  // signed term for this beat: zero, +prod or -prod
  always_comb begin
    w_term = '0;
    if (!w_sel[5]) w_term = w_sel[4] ? -w_ext : w_ext;
  end

  // first beat of a frame overwrites, later beats add (wrapping)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_acc <= '0;
    else if (i_en)    r_acc <= i_first ? w_term : r_acc + w_term;
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/dst7_16_accum.sv
// DST-7 16-point column accumulator: 16 MAC lanes, beat counter and output handshake.
// Optional DST7_ROUND_SHIFT_EN: coef_out is the rounded arithmetic right shift by SHIFT of each sum.
module dst7_16_accum
  import dst7_16_pkg::*;
#(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 32,
  parameter int SHIFT  = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0][PROD_W-1:0]  prod,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N-1:0][ACC_W-1:0]   coef_out
);

  if (SHIFT < 1) begin : g_bad_shift
    $error("dst7_16_accum: SHIFT must be >= 1");
  end

  state_t                   r_state;
  logic [3:0]               r_n;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic                     w_accept;
  logic                     w_first;
  logic [N-1:0][ACC_W-1:0]  w_acc;

  assign w_accept  = in_valid && r_in_ready;
  assign w_first   = (r_n == 4'd0);
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;

  // frame FSM: count 16 accepted beats, then hold the result until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_n         <= 4'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: if (w_accept) begin
          if (r_n == 4'd15) begin
            r_state     <= DONE;
            r_n         <= 4'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_n <= r_n + 4'd1;
          end
        end
        DONE: if (out_ready) begin
          r_state     <= ACCUM;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    dst7_16_mac_lane #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_prod  (prod),
      .i_k     (4'(g)),
      .i_n     (r_n),
      .i_first (w_first),
      .i_en    (w_accept),
      .o_acc   (w_acc[g])
    );
`ifdef DST7_ROUND_SHIFT_EN
    logic [ACC_W-1:0] w_rnd;
    assign w_rnd       = w_acc[g] + (ACC_W'(1) << (SHIFT - 1));
    assign coef_out[g] = $signed(w_rnd) >>> SHIFT;
`else
    assign coef_out[g] = w_acc[g];
`endif
  end

endmodule
